// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared encodings for the data-path RAM arbiter.
//   - data_length / read_write encodings as seen on the RAM pins
//   - arbiter FSM states and requester port ids
//   - ram_req_t: one latched RAM command
//   - req_legal(): alignment / length legality of a request
package ram_ctrl_pkg;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  len;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } ram_req_t;

    // Only the two low address bits matter for alignment.
    function automatic logic req_legal(input logic [1:0] len, input logic [1:0] addr_lo);
        case (len)
            LEN_BYTE: return 1'b1;
            LEN_HALF: return ~addr_lo[0];
            LEN_WORD: return (addr_lo == 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: 2-way round-robin grant, purely combinational.
//   req   [1:0]  request vector, bit PORT_IF = fetch, bit PORT_D = data
//   last         port granted most recently
//   grant [1:0]  one-hot grant (zero when nothing requests)
module ram_rr_arbiter
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: the port that did not go last wins.
            2'b11:   grant = (last == PORT_IF) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one enable/mfc handshake RAM between the fetch
// port and the load/store data port.
//   clk, reset                  clock, async active-high reset
//   if_req/if_addr              fetch request (always a word read)
//   if_ack/if_err/if_rdata      fetch completion pulse, error flag, data
//   d_req/d_rw/d_len/d_addr/d_wdata   data-port request
//   d_ack/d_err/d_rdata         data-port completion
//   ram_enable/read_write/data_length/address/data_in   RAM command
//   ram_data_out/ram_mfc        RAM response
// Every output is a register. Illegal requests complete with err without
// touching the RAM; accesses with no mfc after TIMEOUT cycles complete
// with err.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [8:0]  if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_len,
    input  logic [8:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        ram_enable,
    output logic        ram_read_write,
    output logic [1:0]  ram_data_length,
    output logic [8:0]  ram_address,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    input  logic        ram_mfc
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_n;
    logic        last_q, last_n;
    logic        port_q, port_n;
    logic [7:0]  cnt_q, cnt_n;
    ram_req_t    req_q, req_n;
    logic        en_q, en_n;
    logic        if_ack_q, if_ack_n, if_err_q, if_err_n;
    logic [31:0] if_rdata_q, if_rdata_n;
    logic        d_ack_q, d_ack_n, d_err_q, d_err_n;
    logic [31:0] d_rdata_q, d_rdata_n;

    logic [1:0]  grant;
    logic        gnt_port;
    logic        done_v, done_err, sel;
    logic [31:0] done_data;

    ram_rr_arbiter u_rr (
        .req   ({d_req, if_req}),
        .last  (last_q),
        .grant (grant)
    );

    assign gnt_port = grant[1];

    always_comb begin
        state_n    = state_q;
        last_n     = last_q;
        port_n     = port_q;
        cnt_n      = cnt_q;
        req_n      = req_q;
        en_n       = en_q;
        if_ack_n   = 1'b0;
        if_err_n   = if_err_q;
        if_rdata_n = if_rdata_q;
        d_ack_n    = 1'b0;
        d_err_n    = d_err_q;
        d_rdata_n  = d_rdata_q;
        done_v     = 1'b0;
        done_err   = 1'b0;
        done_data  = '0;
        sel        = port_q;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    last_n = gnt_port;
                    port_n = gnt_port;
                    sel    = gnt_port;
                    if (gnt_port == PORT_D)
                        req_n = '{rw: d_rw, len: d_len, addr: d_addr, wdata: d_wdata};
                    else
                        req_n = '{rw: RW_READ, len: LEN_WORD, addr: if_addr, wdata: 32'd0};
                    if (req_legal(req_n.len, req_n.addr[1:0])) begin
                        en_n    = 1'b1;
                        cnt_n   = 8'd0;
                        state_n = ACCESS;
                    end else begin
                        // Rejected before the RAM ever sees it.
                        done_v   = 1'b1;
                        done_err = 1'b1;
                        state_n  = DONE;
                    end
                end
            end
            ACCESS: begin
                // mfc is tested first so it wins a tie with timeout expiry.
                if (ram_mfc) begin
                    en_n      = 1'b0;
                    done_v    = 1'b1;
                    done_data = (req_q.rw == RW_READ) ? ram_data_out : 32'd0;
                    state_n   = DONE;
                end else if (cnt_q == TO_LAST) begin
                    en_n     = 1'b0;
                    done_v   = 1'b1;
                    done_err = 1'b1;
                    state_n  = DONE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            DONE: begin
                en_n    = 1'b0;
                state_n = IDLE;
            end
            default: begin
                en_n    = 1'b0;
                state_n = IDLE;
            end
        endcase

        // Completion lands in the ack registers, so ack is high during DONE.
        if (done_v) begin
            if (sel == PORT_IF) begin
                if_ack_n   = 1'b1;
                if_err_n   = done_err;
                if_rdata_n = done_data;
            end else begin
                d_ack_n    = 1'b1;
                d_err_n    = done_err;
                d_rdata_n  = done_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= PORT_D;
            port_q     <= PORT_IF;
            cnt_q      <= 8'd0;
            req_q      <= '0;
            en_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= 32'd0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_n;
            last_q     <= last_n;
            port_q     <= port_n;
            cnt_q      <= cnt_n;
            req_q      <= req_n;
            en_q       <= en_n;
            if_ack_q   <= if_ack_n;
            if_err_q   <= if_err_n;
            if_rdata_q <= if_rdata_n;
            d_ack_q    <= d_ack_n;
            d_err_q    <= d_err_n;
            d_rdata_q  <= d_rdata_n;
        end
    end

    assign if_ack          = if_ack_q;
    assign if_err          = if_err_q;
    assign if_rdata        = if_rdata_q;
    assign d_ack           = d_ack_q;
    assign d_err           = d_err_q;
    assign d_rdata         = d_rdata_q;
    assign ram_enable      = en_q;
    assign ram_read_write  = req_q.rw;
    assign ram_data_length = req_q.len;
    assign ram_address     = req_q.addr;
    assign ram_data_in     = req_q.wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a byte-array RAM responder with configurable
// mfc latency (0 = never), a hand-written vector table, reset/arbitration
// sequences, and a randomized phase scored against a transaction model.
module tb_ram_port_arbiter;
    import ram_ctrl_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk, reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_rw;
    logic [1:0]  d_len;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        ram_enable, ram_read_write;
    logic [1:0]  ram_data_length;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;
    logic        ram_mfc;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [512];
    logic [7:0] ref_mem [512];
    int         lat_cfg = 1;
    logic       model_last;

    logic        seen_rw;
    logic [1:0]  seen_len;
    logic [8:0]  seen_addr;
    logic [31:0] seen_wd;

    ram_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .ram_enable(ram_enable), .ram_read_write(ram_read_write),
        .ram_data_length(ram_data_length), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_mfc(ram_mfc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM responder: counts enabled cycles, raises mfc at the negedge of
    // the lat_cfg-th one, drops it once enable falls.
    initial begin
        int cnt;
        int nb;
        logic [31:0] rd;
        cnt = 0;
        ram_mfc = 1'b0;
        ram_data_out = 32'd0;
        forever begin
            @(negedge clk);
            if (!ram_enable) begin
                ram_mfc = 1'b0;
                cnt = 0;
            end else if (!ram_mfc) begin
                cnt++;
                if (lat_cfg != 0 && cnt >= lat_cfg) begin
                    nb = 1 << ram_data_length;
                    rd = 32'd0;
                    for (int i = 0; i < nb && i < 4; i++) begin
                        if (ram_read_write) rd[8*i +: 8] = ram_mem[(int'(ram_address) + i) % 512];
                        else ram_mem[(int'(ram_address) + i) % 512] = ram_data_in[8*i +: 8];
                    end
                    ram_data_out = rd;
                    ram_mfc = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: legality from size/alignment arithmetic, latency from the
    // configured mfc delay capped by TIMEOUT, data from a byte array.
    task automatic predict(input logic port, input logic rw, input logic [1:0] len,
                           input logic [8:0] addr, input logic [31:0] wd,
                           output int exp_n, output logic exp_err,
                           output logic [31:0] exp_rd, output logic exp_en);
        int nb;
        bit legal;
        nb = 1 << len;
        legal = (len != 2'd3) && ((int'(addr) % nb) == 0);
        exp_rd = 32'd0;
        if (!legal) begin
            exp_n = 1; exp_err = 1'b1; exp_en = 1'b0;
        end else begin
            exp_en = 1'b1;
            if (lat_cfg == 0 || lat_cfg > TIMEOUT) begin
                exp_n = TIMEOUT + 1; exp_err = 1'b1;
            end else begin
                exp_n = lat_cfg + 1; exp_err = 1'b0;
                for (int i = 0; i < nb; i++) begin
                    if (rw) exp_rd[8*i +: 8] = ref_mem[(int'(addr) + i) % 512];
                    else ref_mem[(int'(addr) + i) % 512] = wd[8*i +: 8];
                end
            end
        end
        model_last = port;
    endtask

    task automatic wait_any(output int n, output logic gi, output logic gd, output logic en_seen);
        n = 0; gi = 1'b0; gd = 1'b0; en_seen = 1'b0;
        while (n < 40 && !gi && !gd) begin
            @(posedge clk);
            #1;
            n++;
            if (ram_enable && !en_seen) begin
                en_seen   = 1'b1;
                seen_rw   = ram_read_write;
                seen_len  = ram_data_length;
                seen_addr = ram_address;
                seen_wd   = ram_data_in;
            end
            gi = if_ack;
            gd = d_ack;
        end
    endtask

    task automatic expect_ack(input logic port, input int n, input logic gi, input logic gd,
                              input logic en_seen, input int exp_n, input logic exp_err,
                              input logic [31:0] exp_rd, input logic exp_en);
        chk("ack_port", {30'd0, gd, gi}, (port == PORT_IF) ? 32'd1 : 32'd2);
        chk("ack_edges", n, exp_n);
        chk("err", (port == PORT_IF) ? if_err : d_err, exp_err);
        chk("rdata", (port == PORT_IF) ? if_rdata : d_rdata, exp_rd);
        chk("enable_used", en_seen, exp_en);
        chk("enable_low_at_ack", ram_enable, 0);
    endtask

    task automatic drive(input logic port, input logic rw, input logic [1:0] len,
                         input logic [8:0] addr, input logic [31:0] wd);
        if (port == PORT_IF) begin
            if_addr = addr; if_req = 1'b1;
        end else begin
            d_rw = rw; d_len = len; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        end
    endtask

    task automatic drop(input logic port);
        if (port == PORT_IF) if_req = 1'b0; else d_req = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        rw;
        logic [1:0]  len;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_n;
        logic        exp_en;
    } vec_t;

    vec_t vt [12];

    initial begin
        int n, pn;
        logic gi, gd, en_seen, perr, pen, any_ack;
        logic [31:0] prd;
        int lat_opts [8];

        vt[0]  = '{PORT_IF, 1'b1, 2'd2, 9'h008, 32'h0,        1,  1'b0, 32'h00100000, 2,  1'b1};
        vt[1]  = '{PORT_D,  1'b0, 2'd0, 9'h000, 32'h0000000A, 2,  1'b0, 32'h0,        3,  1'b1};
        vt[2]  = '{PORT_D,  1'b1, 2'd0, 9'h000, 32'h0,        1,  1'b0, 32'h0000000A, 2,  1'b1};
        vt[3]  = '{PORT_D,  1'b0, 2'd1, 9'h002, 32'h00000400, 3,  1'b0, 32'h0,        4,  1'b1};
        vt[4]  = '{PORT_D,  1'b1, 2'd1, 9'h002, 32'h0,        1,  1'b0, 32'h00000400, 2,  1'b1};
        vt[5]  = '{PORT_D,  1'b1, 2'd1, 9'h003, 32'h0,        1,  1'b1, 32'h0,        1,  1'b0};
        vt[6]  = '{PORT_D,  1'b1, 2'd3, 9'h000, 32'h0,        1,  1'b1, 32'h0,        1,  1'b0};
        vt[7]  = '{PORT_IF, 1'b1, 2'd2, 9'h006, 32'h0,        1,  1'b1, 32'h0,        1,  1'b0};
        vt[8]  = '{PORT_D,  1'b1, 2'd2, 9'h004, 32'h0,        0,  1'b1, 32'h0,        16, 1'b1};
        vt[9]  = '{PORT_D,  1'b1, 2'd2, 9'h008, 32'h0,        15, 1'b0, 32'h00100000, 16, 1'b1};
        vt[10] = '{PORT_D,  1'b0, 2'd2, 9'h00C, 32'hDEADBEEF, 4,  1'b0, 32'h0,        5,  1'b1};
        vt[11] = '{PORT_IF, 1'b1, 2'd2, 9'h00C, 32'h0,        1,  1'b0, 32'hDEADBEEF, 2,  1'b1};
        lat_opts = '{1, 2, 3, 4, 1, 2, 15, 0};

        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[8] = 8'h00; ram_mem[9] = 8'h00; ram_mem[10] = 8'h10; ram_mem[11] = 8'h00;
        for (int i = 8; i < 12; i++) ref_mem[i] = ram_mem[i];

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_rw = 1'b0; d_len = '0; d_addr = '0; d_wdata = '0;
        model_last = PORT_D;
        repeat (2) @(negedge clk);
        chk("rst_enable", ram_enable, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        chk("rst_ram_regs", {ram_read_write, ram_data_length, ram_address} | ram_data_in, 0);
        reset = 1'b0;

        // Directed vector table.
        for (int v = 0; v < 12; v++) begin
            lat_cfg = vt[v].lat;
            predict(vt[v].port, vt[v].rw, vt[v].len, vt[v].addr, vt[v].wdata, pn, perr, prd, pen);
            @(negedge clk);
            drive(vt[v].port, vt[v].rw, vt[v].len, vt[v].addr, vt[v].wdata);
            wait_any(n, gi, gd, en_seen);
            expect_ack(vt[v].port, n, gi, gd, en_seen, vt[v].exp_n, vt[v].exp_err, vt[v].exp_rd, vt[v].exp_en);
            if (vt[v].exp_en) begin
                chk("ram_len", seen_len, vt[v].len);
                chk("ram_addr", seen_addr, vt[v].addr);
                chk("ram_rw", seen_rw, vt[v].rw);
                if (!vt[v].rw) chk("ram_wdata", seen_wd, vt[v].wdata);
            end
            @(negedge clk);
            drop(vt[v].port);
        end

        // Reset during ACCESS: enable must drop immediately, no ack follows.
        lat_cfg = 0;
        @(negedge clk);
        drive(PORT_D, 1'b1, 2'd2, 9'h010, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_enable", ram_enable, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_enable", ram_enable, 0);
        chk("mid_rst_ack", if_ack | d_ack, 0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last = PORT_D;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_ack = any_ack | if_ack | d_ack;
        end
        chk("post_rst_no_ack", any_ack, 0);

        // Both held after reset: fetch, data, fetch, data.
        lat_cfg = 1;
        @(negedge clk);
        drive(PORT_IF, 1'b1, 2'd2, 9'h008, 32'h0);
        drive(PORT_D, 1'b1, 2'd0, 9'h000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) predict(PORT_IF, 1'b1, 2'd2, 9'h008, 32'h0, pn, perr, prd, pen);
            else            predict(PORT_D, 1'b1, 2'd0, 9'h000, 32'h0, pn, perr, prd, pen);
            wait_any(n, gi, gd, en_seen);
            expect_ack((k % 2 == 0) ? PORT_IF : PORT_D, n, gi, gd, en_seen,
                       (k == 0) ? pn : pn + 1, perr, prd, pen);
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            int mode;
            logic [1:0] dl;
            logic [8:0] da, ia;
            logic drw, w, o;
            logic [31:0] dwd;
            int pn2;
            logic perr2, pen2;
            logic [31:0] prd2;
            mode = $urandom_range(0, 2);
            lat_cfg = lat_opts[$urandom_range(0, 7)];
            drw = 1'($urandom_range(0, 1));
            dl  = 2'($urandom_range(0, 3));
            da  = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0 && dl != 2'd3) da = da & ~9'((1 << dl) - 1);
            dwd = $urandom;
            ia  = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) ia = ia & 9'h1FC;
            @(negedge clk);
            if (mode == 0 || mode == 1) begin
                w = (mode == 0) ? PORT_IF : PORT_D;
                if (w == PORT_IF) predict(PORT_IF, 1'b1, 2'd2, ia, 32'h0, pn, perr, prd, pen);
                else              predict(PORT_D, drw, dl, da, dwd, pn, perr, prd, pen);
                drive(w, drw, (w == PORT_IF) ? 2'd2 : dl, (w == PORT_IF) ? ia : da, dwd);
                wait_any(n, gi, gd, en_seen);
                expect_ack(w, n, gi, gd, en_seen, pn, perr, prd, pen);
                @(negedge clk);
                drop(w);
            end else begin
                w = (model_last == PORT_D) ? PORT_IF : PORT_D;
                o = ~w;
                if (w == PORT_IF) begin
                    predict(PORT_IF, 1'b1, 2'd2, ia, 32'h0, pn, perr, prd, pen);
                    predict(PORT_D, drw, dl, da, dwd, pn2, perr2, prd2, pen2);
                end else begin
                    predict(PORT_D, drw, dl, da, dwd, pn, perr, prd, pen);
                    predict(PORT_IF, 1'b1, 2'd2, ia, 32'h0, pn2, perr2, prd2, pen2);
                end
                drive(PORT_IF, 1'b1, 2'd2, ia, 32'h0);
                drive(PORT_D, drw, dl, da, dwd);
                wait_any(n, gi, gd, en_seen);
                expect_ack(w, n, gi, gd, en_seen, pn, perr, prd, pen);
                @(negedge clk);
                drop(w);
                wait_any(n, gi, gd, en_seen);
                expect_ack(o, n, gi, gd, en_seen, pn2 + 1, perr2, prd2, pen2);
                @(negedge clk);
                drop(o);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Sequencing arbiter that shares the single asynchronous-handshake data-path RAM (enable / read_write / data_length / address / data_in in; data_out / mfc out) between the instruction-fetch port and the load/store data port. It drives the RAM enable, holds it until mfc returns, and converts the handshake into a clocked req/ack transaction per requester. It also rejects misaligned or illegal requests and bounds every access with an mfc timeout.

## Interface
- TIMEOUT, 15: max cycles in ACCESS waiting for mfc before error completion (1..255)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request (always word read)
- if_addr  in  9  fetch byte address
- if_ack  out  1  one-cycle completion pulse, fetch
- if_err  out  1  valid with if_ack; 1 = misaligned or timeout
- if_rdata  out  32  read data, valid with if_ack
- d_req  in  1  data-port request
- d_rw  in  1  1 = read, 0 = write (RAM read_write encoding)
- d_len  in  2  0 byte, 1 halfword, 2 word, 3 illegal
- d_addr  in  9  data byte address
- d_wdata  in  32  write data, right-justified
- d_ack / d_err / d_rdata  out  1/1/32  as fetch-port equivalents
- ram_enable  out  1  to RAM enable
- ram_read_write, ram_data_length, ram_address, ram_data_in  out  1/2/9/32  to RAM
- ram_data_out  in  32  from RAM
- ram_mfc  in  1  memory function complete

## Operation
- FSM: IDLE, ACCESS, DONE. All outputs registered.
- IDLE: sample if_req/d_req each edge. None -> stay. Grant per round-robin pointer `last`: only one requesting -> that one; both -> the one not equal to `last`. Latch granted rw/len/addr/wdata (fetch: rw=1, len=2) into ram_* registers; `last` <= granted.
- Legality check at grant: len==3, len==1 with addr[0]==1, len==2 with addr[1:0]!=0 -> go DONE with err=1, ram_enable stays 0, rdata=0. Otherwise go ACCESS, ram_enable<=1, timeout counter<=0.
- ACCESS: ram_enable high, ram_* stable. Edge with ram_mfc==1 -> capture ram_data_out (reads; writes capture 0), err=0, ram_enable<=0, go DONE. Else counter+1; counter reaching TIMEOUT-1 without mfc -> ram_enable<=0, err=1, rdata=0, go DONE.
- DONE: granted port's ack=1 for exactly one cycle with err/rdata; other port's ack=0. Go IDLE. ram_enable 0.
- Requester holds req and inputs stable until it sees ack; it may change/deassert them at the edge ending the ack cycle.
- Read data passed through unmodified (RAM zero-extends byte/halfword).

## Timing
- Reset (async, immediate): state IDLE, last=data (so fetch wins first tie... then alternates), all outputs 0 (ram_enable, acks, errs, rdata, ram_* registers). Reset mid-ACCESS drops ram_enable at once; no ack issued.
- Legal access, mfc seen at k-th ACCESS edge (k>=1): req sampled edge E0, enable high E0..E0+k, ack high cycle E0+k..E0+k+1. Minimum request-to-ack = 2 edges.
- Illegal request: ack with err one cycle after grant edge.
- Timeout: ack/err after TIMEOUT ACCESS cycles.
- ram_enable always low for >=2 cycles (DONE + IDLE) between accesses; RAM sees a clean enable pulse per transaction.
- Back-to-back both-requesting: strict alternation, no starvation; a single persistent requester gets every slot.
- mfc arriving on the same edge as timeout expiry: mfc wins, err=0.
- req changing while not granted: ignored until next IDLE sample.

## Structure
- Package ram_ctrl_pkg: LEN_BYTE=2'd0, LEN_HALF=2'd1, LEN_WORD=2'd2, RW_READ=1'b1, RW_WRITE=1'b0, state encodings IDLE/ACCESS/DONE, port ids PORT_IF/PORT_D.
- Sub-module ram_rr_arbiter: 2-way round-robin grant (inputs req[1:0], last; output grant one-hot, combinational). FSM, check logic, timeout counter in ram_port_arbiter.

## Test plan
- Reset, then fetch only, if_addr=9'h008, RAM preloaded word 32'h00100000 at 8 -> if_ack one cycle, if_rdata=32'h00100000, if_err=0, ram_data_length=2.
- Data write byte d_len=0, d_addr=0, d_wdata=32'h0A then data read byte addr 0 -> d_rdata=32'h0000000A; halfword write 32'h0400 at 2 reads back 32'h00000400.
- if_req and d_req high same edge after reset, both held -> grants fetch, data, fetch, data; each ack once per transaction.
- d_len=1, d_addr=9'h003 -> d_ack with d_err=1 next cycle, ram_enable never asserted; d_len=3 likewise.
- RAM model with mfc stuck 0, TIMEOUT=15 -> ack with err=1, rdata=0 after 15 ACCESS cycles, ram_enable low afterwards.
- Assert reset during ACCESS -> ram_enable 0 immediately, no ack; next request completes normally.
